pipe_addsub_v: RTL and testbench

PIPE_ADDSUB_V -- requirements
Module: pipe_addsub_v

---
 rtl/adder_pkg.sv | 14 +
 rtl/addsub_stage_v.sv | 29 ++
 rtl/pipe_addsub_v.sv | 141 ++++++++++++++
 tb/tb_pipe_addsub_v.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract block: op encodings and
// the helper that derives the per-stage segment width.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int seg_width(input int data_width, input int stages);
    return data_width / stages;
  endfunction

endpackage

// File: rtl/addsub_stage_v.sv
// One SEG-bit slice of the pipelined adder: adds its operand segments with the
// incoming carry and registers sum, carry-out and the beat valid bit.
module addsub_stage_v #(
  parameter int SEG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           valid_in,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic           valid,
  output logic [SEG-1:0] sum,
  output logic           carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      valid        <= valid_in;
      {carry, sum} <= {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, carry_in};
    end
  end

endmodule

// File: rtl/pipe_addsub_v.sv
// Segmented, bubble-collapsing pipelined adder/subtractor with Cout/Ovf/Zero.
// Optional saturation (sat_mode input) is built when ADDSUB_SAT_EN is defined.
module pipe_addsub_v
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Ci,
  input  logic                  op,
`ifdef ADDSUB_SAT_EN
  input  logic                  sat_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Sum,
  output logic                  Cout,
  output logic                  Ovf,
  output logic                  Zero
);

  localparam int SEG  = seg_width(DATA_WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  // Handshake: a beat moves when valid and ready are both high in the same
  // cycle; valid never waits on ready, and a stalled output holds its value.
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  c_first;

  assign b_eff   = (op == OP_SUB) ? ~B : B;
  assign c_first = (op == OP_ADD) ? Ci : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                  load, v_in, c_in, valid, c_out;
    logic [SEG-1:0]        sum_seg;
    logic [DATA_WIDTH-1:0] a_in, b_in, acc_in, a_q, b_q, acc_q;
    logic                  unused_skew;
`ifdef ADDSUB_SAT_EN
    logic                  sat_in, sat_q;
`endif

    if (k == 0) begin : g_head
      assign a_in   = A;
      assign b_in   = b_eff;
      assign acc_in = '0;
      assign v_in   = in_valid;
      assign c_in   = c_first;
`ifdef ADDSUB_SAT_EN
      assign sat_in = sat_mode;
`endif
    end else begin : g_body
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign v_in = g_stage[k-1].valid;
      assign c_in = g_stage[k-1].c_out;
`ifdef ADDSUB_SAT_EN
      assign sat_in = g_stage[k-1].sat_q;
`endif
      // Fold the previous stage's finished segment into the partial result.
      always_comb begin
        acc_in                     = g_stage[k-1].acc_q;
        acc_in[(k-1)*SEG +: SEG]   = g_stage[k-1].sum_seg;
      end
    end

    // Bubble collapsing: a stage loads when empty or when its contents move on.
    if (k == LAST) begin : g_tail
      assign load = !valid || out_ready;
    end else begin : g_mid
      assign load = !valid || g_stage[k+1].load;
    end

    addsub_stage_v #(.SEG(SEG)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .valid_in (v_in),
      .a        (a_in[k*SEG +: SEG]),
      .b        (b_in[k*SEG +: SEG]),
      .carry_in (c_in),
      .valid    (valid),
      .sum      (sum_seg),
      .carry    (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        acc_q <= '0;
      end else if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        acc_q <= acc_in;
      end
    end

`ifdef ADDSUB_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sat_q <= 1'b0;
      else if (load) sat_q <= sat_in;
    end
`endif

    // Already-consumed operand segments stay in the skew words unread.
    assign unused_skew = ^{a_q, b_q};
  end

  logic [DATA_WIDTH-1:0] raw;

  always_comb begin
    raw                    = g_stage[LAST].acc_q;
    raw[LAST*SEG +: SEG]   = g_stage[LAST].sum_seg;
  end

  assign in_ready  = rst_n && g_stage[0].load;
  assign out_valid = g_stage[LAST].valid;
  assign Cout      = g_stage[LAST].c_out;
  // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
  assign Ovf       = Cout ^ raw[DATA_WIDTH-1]
                   ^ g_stage[LAST].a_q[DATA_WIDTH-1] ^ g_stage[LAST].b_q[DATA_WIDTH-1];

`ifdef ADDSUB_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // A set result MSB on overflow means the true result was positive.
  assign Sum = (g_stage[LAST].sat_q && Ovf) ? (raw[DATA_WIDTH-1] ? SMAX : SMIN) : raw;
`else
  assign Sum = raw;
`endif

  assign Zero = out_valid && (Sum == '0);

endmodule

// File: tb/tb_pipe_addsub_v.sv
// Self-checking bench for pipe_addsub_v (DATA_WIDTH=8, STAGES=2): vector table,
// hand-written stall/reset sequences and a randomized backpressure run.
module tb_pipe_addsub_v;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       Ci, op, sat_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Sum;
  logic       Cout, Ovf, Zero;

  pipe_addsub_v #(.DATA_WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .op        (op),
`ifdef ADDSUB_SAT_EN
    .sat_mode  (sat_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {Sum, Cout, Ovf, Zero}
  int n_cmp  = 0;
  int n_bad  = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic o, input logic s);
    logic [7:0] bp, sm;
    logic [8:0] full;
    logic       ov;
    bp   = o ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {8'd0, (o ? 1'b1 : ci)};
    sm   = full[7:0];
    ov   = (a[7] == bp[7]) && (sm[7] != a[7]);
    if (s && ov) sm = a[7] ? 8'h80 : 8'h7F;
    return {sm, full[8], ov, (sm == 8'h00)};
  endfunction

  // Output monitor: sampled well after the falling edge, once drivers settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h expected none", {Sum, Cout, Ovf, Zero});
        end else begin
          check("out_beat", {Sum, Cout, Ovf, Zero}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic o, input logic s, input logic [10:0] exp, input bit rand_bp);
    int tries;
    tries    = 0;
    A        = a;
    B        = b;
    Ci       = ci;
    op       = o;
    sat_mode = s;
    in_valid = 1'b1;
    if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
    #1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
      #1;
      tries++;
      stalls++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a, b;
    logic       ci, op, sat;
    logic [7:0] sum;
    logic       cout, ovf, zero;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h03, 8'h05, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 8'hDE, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    // ---- reset state ----
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A = '0; B = '0; Ci = 1'b0; op = 1'b0; sat_mode = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", {21'd0, Sum, Cout, Ovf, Zero}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 check("ready_after_rst", 32'(in_ready), 32'd1);

    // ---- latency: out_valid exactly two cycles after acceptance ----
    @(negedge clk);
    send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1}, 1'b0);
    #1 check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("lat_cycle2", 32'(out_valid), 32'd1);
    wait_drain();

    // ---- table, back-to-back with out_ready held high ----
    @(negedge clk);
    stalls = 0;
    for (int i = 0; i < 10; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].op, tbl[i].sat,
           {tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero}, 1'b0);
    check("throughput_stalls", 32'(stalls), 32'd0);
    wait_drain();

`ifdef ADDSUB_SAT_EN
    @(negedge clk);
    send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, {8'h80, 1'b1, 1'b1, 1'b0}, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, {8'h7F, 1'b0, 1'b1, 1'b0}, 1'b0);
    wait_drain();
`endif

    // ---- fill under backpressure, then release ----
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, {8'h33, 3'b000}, 1'b0);
    send(8'h50, 8'h50, 1'b0, 1'b0, 1'b0, {8'hA0, 3'b010}, 1'b0);
    A = 8'h90; B = 8'h10; Ci = 1'b0; op = 1'b1; sat_mode = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", {21'd0, Sum, Cout, Ovf, Zero}, {21'd0, 8'h33, 3'b000});
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'h90, 8'h10, 1'b0, 1'b1, 1'b0, {8'h80, 3'b100}, 1'b0);
    send(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, {8'hFF, 3'b000}, 1'b0);
    wait_drain();

    // ---- reset with two beats in flight ----
    @(negedge clk);
    out_ready = 1'b1;
    send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, {8'h03, 3'b000}, 1'b0);
    out_ready = 1'b0;
    send(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, {8'h07, 3'b000}, 1'b0);
    #1 check("inflight_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_flags", {21'd0, Sum, Cout, Ovf, Zero}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #1 check("midrst_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("no_ghost_out", 32'(out_valid), 32'd0);
    end

    // ---- randomized run with random backpressure ----
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rc, ro, rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
`ifdef ADDSUB_SAT_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rc, ro, rs, model(ra, rb, rc, ro, rs), 1'b1);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
